// File: rtl/ptt144_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ptt144_pkg : state encodings and sense patterns for ptt_ctrl144
// Rev 1.0
// ---------------------------------------------------------------------------
package ptt144_pkg;

  localparam int STATE_W = 6;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE    = 6'b000001;
  localparam state_t S_WAIT_TX = 6'b000010;
  localparam state_t S_TX      = 6'b000100;
  localparam state_t S_TAIL    = 6'b001000;
  localparam state_t S_WAIT_RX = 6'b010000;
  localparam state_t S_FAULT   = 6'b100000;

  // {lna, a, pa}
  localparam logic [2:0] SENSE_TX = 3'b011;
  localparam logic [2:0] SENSE_RX = 3'b100;

endpackage
`default_nettype wire

// File: rtl/ptt144_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ptt144_debounce : 2-FF synchronizer plus stable-count debounce, idles high
// Rev 1.0
// ---------------------------------------------------------------------------
module ptt144_debounce #(
  parameter int CNT_SIZE     = 21,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic                meta;
  logic                sync;
  logic [CNT_SIZE-1:0] cnt;

  localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'(DEBOUNCE_CNT);

  // A new value is adopted on its (DEBOUNCE_CNT+1)-th consecutive cycle;
  // any return to the current output restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ptt_ctrl144.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ptt_ctrl144 : 144 MHz PTT debounce and TX-grant sequencing controller.
// Define PTT144_SENSE_EN for closed-loop chain supervision.  Rev 1.0
// ---------------------------------------------------------------------------
module ptt_ctrl144
  import ptt144_pkg::*;
#(
  parameter int CNT_SIZE      = 21,
  parameter int DEBOUNCE_CNT  = 3,
  parameter int SENSE_TIMEOUT = 16,
  parameter int TX_TAIL       = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ptt_in,
`ifdef PTT144_SENSE_EN
  input  logic lna_sense,
  input  logic a_sense,
  input  logic pa_sense,
`endif
  output logic ptt_req,
  output logic tx_enable,
  output logic fault
);

  localparam logic [CNT_SIZE-1:0] TIMEOUT_LD = CNT_SIZE'(SENSE_TIMEOUT);
  localparam logic [CNT_SIZE-1:0] TAIL_LD    = CNT_SIZE'(TX_TAIL);

  logic ptt_db;

  ptt144_debounce #(
    .CNT_SIZE     (CNT_SIZE),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_ptt_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ptt_in),
    .dout    (ptt_db)
  );

`ifdef PTT144_SENSE_EN
  logic [2:0] sense_meta;
  logic [2:0] sense_sync;
  logic       sense_tx;
  logic       sense_rx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sense_meta <= '0;
      sense_sync <= '0;
    end else begin
      sense_meta <= {lna_sense, a_sense, pa_sense};
      sense_sync <= sense_meta;
    end
  end

  assign sense_tx = (sense_sync == SENSE_TX);
  assign sense_rx = (sense_sync == SENSE_RX);
`endif

  state_t              state;
  state_t              state_nxt;
  logic [CNT_SIZE-1:0] timer;
  logic [CNT_SIZE-1:0] timer_val;
  logic                timer_load;
  logic                timer_zero;

  assign timer_zero = (timer == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Down-counter saturating at zero; loaded only on the listed transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (timer_load) begin
      timer <= timer_val;
    end else if (!timer_zero) begin
      timer <= timer - 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_val  = TIMEOUT_LD;
    case (state)
      S_IDLE: begin
        if (!ptt_db) begin
          state_nxt  = S_WAIT_TX;
          timer_load = 1'b1;
        end
      end
      S_WAIT_TX: begin
`ifdef PTT144_SENSE_EN
        if (sense_tx) begin
          state_nxt = S_TX;
        end else if (ptt_db) begin
          state_nxt  = S_WAIT_RX;
          timer_load = 1'b1;
        end else if (timer_zero) begin
          state_nxt = S_FAULT;
        end
`else
        if (timer_zero) begin
          state_nxt = S_TX;
        end else if (ptt_db) begin
          state_nxt  = S_WAIT_RX;
          timer_load = 1'b1;
        end
`endif
      end
      S_TX: begin
        // Unkey wins over a simultaneous chain deviation.
        if (ptt_db) begin
          state_nxt  = S_TAIL;
          timer_load = 1'b1;
          timer_val  = TAIL_LD;
        end
`ifdef PTT144_SENSE_EN
        else if (!sense_tx) begin
          state_nxt = S_FAULT;
        end
`endif
      end
      S_TAIL: begin
        if (timer_zero) begin
          state_nxt  = S_WAIT_RX;
          timer_load = 1'b1;
        end
      end
      S_WAIT_RX: begin
`ifdef PTT144_SENSE_EN
        if (sense_rx) begin
          state_nxt = S_IDLE;
        end else if (timer_zero) begin
          state_nxt = S_FAULT;
        end
`else
        if (timer_zero) begin
          state_nxt = S_IDLE;
        end
`endif
      end
      S_FAULT: begin
`ifdef PTT144_SENSE_EN
        if (ptt_db && sense_rx) begin
          state_nxt = S_IDLE;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode directly from state flops; illegal vectors read as IDLE.
  always_comb begin
    ptt_req   = 1'b1;
    tx_enable = 1'b0;
    fault     = 1'b0;
    case (state)
      S_WAIT_TX: ptt_req = 1'b0;
      S_TAIL:    ptt_req = 1'b0;
      S_TX: begin
        ptt_req   = 1'b0;
        tx_enable = 1'b1;
      end
`ifdef PTT144_SENSE_EN
      S_FAULT:   fault = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ptt_ctrl144.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ptt_ctrl144 : table-driven and scoreboard bench for ptt_ctrl144
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ptt_ctrl144;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       ptt_in  = 1'b1;
  logic [2:0] sense   = 3'b100;
  logic       ptt_req;
  logic       tx_enable;
  logic       fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ptt_ctrl144 #(
    .CNT_SIZE      (21),
    .DEBOUNCE_CNT  (3),
    .SENSE_TIMEOUT (16),
    .TX_TAIL       (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ptt_in    (ptt_in),
`ifdef PTT144_SENSE_EN
    .lna_sense (sense[2]),
    .a_sense   (sense[1]),
    .pa_sense  (sense[0]),
`endif
    .ptt_req   (ptt_req),
    .tx_enable (tx_enable),
    .fault     (fault)
  );

  typedef struct packed {
    logic       ptt;
    logic [2:0] sense;
    logic [7:0] dly;
    logic [2:0] exp;   // {ptt_req, tx_enable, fault}
    logic [7:0] adv;
  } row_t;

  row_t tbl [0:11];
  int   n_rows;

  int         q_due  [$];
  logic [2:0] q_exp  [$];
  string      q_name [$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: req/tx/flt got %b want %b (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_at(input int dly, input logic [2:0] e, input string nm);
    q_due.push_back(cyc + dly);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  task automatic scan();
    if (reset_n) begin
      total++;
      if (tx_enable && ptt_req) begin
        bad++;
        $display("FAIL overlap: tx_enable=%b ptt_req=%b want not both 1 (cyc %0d)",
                 tx_enable, ptt_req, cyc);
      end
    end
    for (int i = q_due.size() - 1; i >= 0; i--) begin
      if (q_due[i] == cyc) begin
        check(q_name[i], {ptt_req, tx_enable, fault}, q_exp[i]);
        q_due.delete(i);
        q_exp.delete(i);
        q_name.delete(i);
      end
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        scan();
      end
    join_none

`ifdef PTT144_SENSE_EN
    tbl[0]  = '{1'b0, 3'b100, 8'd6,  3'b100, 8'd0};
    tbl[1]  = '{1'b0, 3'b100, 8'd7,  3'b000, 8'd5};
    tbl[2]  = '{1'b0, 3'b011, 8'd2,  3'b000, 8'd0};
    tbl[3]  = '{1'b0, 3'b011, 8'd3,  3'b010, 8'd10};
    tbl[4]  = '{1'b1, 3'b011, 8'd6,  3'b010, 8'd0};
    tbl[5]  = '{1'b1, 3'b011, 8'd7,  3'b000, 8'd0};
    tbl[6]  = '{1'b1, 3'b011, 8'd9,  3'b000, 8'd0};
    tbl[7]  = '{1'b1, 3'b011, 8'd10, 3'b100, 8'd12};
    tbl[8]  = '{1'b1, 3'b100, 8'd3,  3'b100, 8'd5};
    tbl[9]  = '{1'b1, 3'b100, 8'd20, 3'b100, 8'd25};
    n_rows  = 10;
`else
    tbl[0]  = '{1'b0, 3'b100, 8'd6,  3'b100, 8'd0};
    tbl[1]  = '{1'b0, 3'b100, 8'd7,  3'b000, 8'd0};
    tbl[2]  = '{1'b0, 3'b100, 8'd23, 3'b000, 8'd0};
    tbl[3]  = '{1'b0, 3'b100, 8'd24, 3'b010, 8'd30};
    tbl[4]  = '{1'b1, 3'b100, 8'd6,  3'b010, 8'd0};
    tbl[5]  = '{1'b1, 3'b100, 8'd7,  3'b000, 8'd0};
    tbl[6]  = '{1'b1, 3'b100, 8'd9,  3'b000, 8'd0};
    tbl[7]  = '{1'b1, 3'b100, 8'd10, 3'b100, 8'd0};
    tbl[8]  = '{1'b1, 3'b100, 8'd26, 3'b100, 8'd30};
    n_rows  = 9;
`endif

    // reset values, visible while reset is still held
    #2;
    check("reset_async", {ptt_req, tx_enable, fault}, 3'b100);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_at(1, 3'b100, "reset_state");
    tick(3);

    // clean key / unkey
    for (int i = 0; i < n_rows; i++) begin
      ptt_in = tbl[i].ptt;
      sense  = tbl[i].sense;
      exp_at(int'(tbl[i].dly), tbl[i].exp, $sformatf("tbl%0d", i));
      if (tbl[i].adv != 8'd0) tick(int'(tbl[i].adv));
    end
    tick(10);

    // bounce: 2-cycle low pulses never survive the debounce
    for (int k = 1; k <= 30; k++) exp_at(k, 3'b100, "bounce");
    for (int k = 0; k < 10; k++) begin
      ptt_in = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    ptt_in = 1'b1;
    tick(15);

`ifdef PTT144_SENSE_EN
    // chain timeout with sense stuck at RX
    sense  = 3'b100;
    ptt_in = 1'b0;
    exp_at(23, 3'b000, "cto_pre");
    exp_at(24, 3'b101, "cto_fault");
    tick(26);
    ptt_in = 1'b1;
    exp_at(6, 3'b101, "cto_hold");
    exp_at(7, 3'b100, "cto_clear");
    tick(10);

    // PA dropout while transmitting
    ptt_in = 1'b0;
    tick(5);
    sense = 3'b011;
    exp_at(3, 3'b010, "pa_tx");
    tick(7);
    sense = 3'b010;
    exp_at(2, 3'b010, "pa_pre");
    exp_at(3, 3'b101, "pa_fault");
    tick(3);
    ptt_in = 1'b1;
    sense  = 3'b100;
    exp_at(6, 3'b101, "pa_hold");
    exp_at(7, 3'b100, "pa_clear");
    tick(10);
`endif

    // abort during WAIT_TX
    sense  = 3'b100;
    ptt_in = 1'b0;
    exp_at(7, 3'b000, "abort_wtx");
    tick(8);
    ptt_in = 1'b1;
    for (int k = 1; k <= 6; k++) exp_at(k, 3'b000, "abort_hold");
    exp_at(7, 3'b100, "abort_wrx");
    tick(40);

    // asynchronous reset in the middle of TX
    ptt_in = 1'b0;
`ifdef PTT144_SENSE_EN
    tick(5);
    sense = 3'b011;
    tick(6);
`else
    tick(26);
`endif
    check("pre_rst_tx", {ptt_req, tx_enable, fault}, 3'b010);
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx", {ptt_req, tx_enable, fault}, 3'b100);
    ptt_in = 1'b1;
    sense  = 3'b100;
    tick(2);
    reset_n = 1'b1;
    exp_at(3, 3'b100, "post_rst");
    tick(5);

    // drain with a bound; anything left over never matured
    for (int w = 0; w < 100 && q_due.size() > 0; w++) tick(1);
    while (q_due.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: never checked, due cyc %0d want %b", q_name[0], q_due[0], q_exp[0]);
      q_due.delete(0);
      q_exp.delete(0);
      q_name.delete(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
